keypad_sequencer: RTL and testbench

//   Upstream feeder for combination_lock. Collects a 12-key keypad entry (3 groups x 4

---
 rtl/comb_lock_pkg.sv | 27 ++
 rtl/key_onehot_enc.sv | 17 +
 rtl/keypad_sequencer.sv | 102 ++++++++++
 tb/tb_keypad_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/comb_lock_pkg.sv
// rtl/comb_lock_pkg.sv - shared digit encodings and types for the keypad/lock pair
package comb_lock_pkg;
  localparam int DIGIT_W     = 10;
  localparam int DIG_PER_GRP = 4;
  localparam int NUM_GROUPS  = 3;

  typedef bit [DIGIT_W-1:0] digit_t;
  typedef digit_t [DIG_PER_GRP-1:0] group_t;

  typedef enum logic {
    COLLECT = 1'b0,
    PLAY    = 1'b1
  } seq_state_t;

  localparam digit_t C0 = 10'b00_0000_0001;
  localparam digit_t C1 = 10'b00_0000_0010;
  localparam digit_t C2 = 10'b00_0000_0100;
  localparam digit_t C3 = 10'b00_0000_1000;
  localparam digit_t C4 = 10'b00_0001_0000;
  localparam digit_t C5 = 10'b00_0010_0000;
  localparam digit_t C6 = 10'b00_0100_0000;
  localparam digit_t C7 = 10'b00_1000_0000;
  localparam digit_t C8 = 10'b01_0000_0000;
  localparam digit_t C9 = 10'b10_0000_0000;

  localparam digit_t IDLE_DIGIT = C0;
endpackage

// File: rtl/key_onehot_enc.sv
// rtl/key_onehot_enc.sv - binary key code to one-hot digit with illegal-code flag
module key_onehot_enc
  import comb_lock_pkg::*;
(
  input  logic [3:0] code_i,
  output digit_t     onehot_o,
  output logic       illegal_o
);

  // Illegal codes still yield a one-hot value so nothing downstream ever sees zero.
  always_comb begin
    illegal_o = (code_i > 4'd9);
    onehot_o  = C0;
    if (!illegal_o) onehot_o = digit_t'(1) << code_i;
  end

endmodule

// File: rtl/keypad_sequencer.sv
// rtl/keypad_sequencer.sv - collects a 12-key entry and replays it as 3 one-hot groups
module keypad_sequencer
  import comb_lock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       key_clear,
  output logic       key_ready,
  output logic       key_err,
  output digit_t     digits [DIG_PER_GRP-1:0],
  output logic       play_valid,
  output logic [1:0] group_idx,
  output logic       busy
);

  localparam logic [3:0] LAST_KEY   = 4'(NUM_GROUPS * DIG_PER_GRP - 1);
  localparam logic [1:0] LAST_GROUP = 2'(NUM_GROUPS - 1);

  seq_state_t                  state_q, state_d;
  logic [3:0]                  key_cnt_q, key_cnt_d;
  logic [1:0]                  play_cnt_q, play_cnt_d;
  logic                        key_err_q, key_err_d;
  group_t [NUM_GROUPS-1:0]     buf_q, buf_d;

  digit_t enc_onehot;
  logic   enc_illegal;

  key_onehot_enc u_enc (
    .code_i    (key_code),
    .onehot_o  (enc_onehot),
    .illegal_o (enc_illegal)
  );

  always_comb begin
    state_d    = state_q;
    key_cnt_d  = key_cnt_q;
    play_cnt_d = play_cnt_q;
    key_err_d  = 1'b0;
    buf_d      = buf_q;
    case (state_q)
      COLLECT: begin
        // Clear takes priority over a simultaneous key.
        if (key_clear) begin
          key_cnt_d = 4'd0;
        end else if (key_valid) begin
          if (enc_illegal) begin
            key_err_d = 1'b1;
          end else begin
            buf_d[key_cnt_q[3:2]][2'd3 - key_cnt_q[1:0]] = enc_onehot;
            if (key_cnt_q == LAST_KEY) begin
              key_cnt_d  = 4'd0;
              play_cnt_d = 2'd0;
              state_d    = PLAY;
            end else begin
              key_cnt_d = key_cnt_q + 4'd1;
            end
          end
        end
      end
      PLAY: begin
        if (play_cnt_q == LAST_GROUP) begin
          play_cnt_d = 2'd0;
          state_d    = COLLECT;
        end else begin
          play_cnt_d = play_cnt_q + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      key_cnt_q  <= 4'd0;
      play_cnt_q <= 2'd0;
      key_err_q  <= 1'b0;
      buf_q      <= {(NUM_GROUPS * DIG_PER_GRP){IDLE_DIGIT}};
    end else begin
      state_q    <= state_d;
      key_cnt_q  <= key_cnt_d;
      play_cnt_q <= play_cnt_d;
      key_err_q  <= key_err_d;
      buf_q      <= buf_d;
    end
  end

  assign key_ready  = (state_q == COLLECT);
  assign busy       = ~key_ready;
  assign play_valid = (state_q == PLAY);
  assign group_idx  = play_cnt_q;
  assign key_err    = key_err_q;

  // Output mux sees only registers, so reset forces idle digits without a clock.
  always_comb begin
    for (int i = 0; i < DIG_PER_GRP; i++) begin
      digits[i] = play_valid ? buf_q[play_cnt_q][i] : IDLE_DIGIT;
    end
  end

endmodule

// File: tb/tb_keypad_sequencer.sv
// tb/tb_keypad_sequencer.sv - scoreboard bench for keypad_sequencer
module tb_keypad_sequencer;
  import comb_lock_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       key_clear = 1'b0;
  logic       key_ready, key_err, play_valid, busy;
  logic [1:0] group_idx;
  digit_t     digits [DIG_PER_GRP-1:0];

  keypad_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_clear  (key_clear),
    .key_ready  (key_ready),
    .key_err    (key_err),
    .digits     (digits),
    .play_valid (play_valid),
    .group_idx  (group_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_play = 1'b0;
  int          m_cnt  = 0;
  int          m_pc   = 0;
  bit          m_err  = 1'b0;
  int          entry [12];
  logic [39:0] sb [$];

  localparam logic [39:0] IDLE_PACK = {4{10'd1}};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [39:0] exp_group(input int g);
    logic [39:0] r;
    logic [9:0]  one;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      one = 10'd1 << entry[g*4 + k];
      r[(3-k)*10 +: 10] = one;
    end
    return r;
  endfunction

  task automatic model_edge(input bit v, input logic [3:0] c, input bit clr);
    m_err = 1'b0;
    if (!m_play) begin
      if (clr) begin
        m_cnt = 0;
      end else if (v) begin
        if (c > 4'd9) begin
          m_err = 1'b1;
        end else begin
          entry[m_cnt] = int'(c);
          m_cnt++;
          if (m_cnt == 12) begin
            for (int g = 0; g < 3; g++) sb.push_back(exp_group(g));
            m_cnt  = 0;
            m_play = 1'b1;
            m_pc   = 0;
          end
        end
      end
    end else if (m_pc == 2) begin
      m_play = 1'b0;
      m_pc   = 0;
    end else begin
      m_pc++;
    end
  endtask

  function automatic logic [39:0] pack_digits();
    return {digits[3], digits[2], digits[1], digits[0]};
  endfunction

  task automatic compare_outputs();
    logic [39:0] dig;
    logic [39:0] e;
    dig = pack_digits();
    check_eq("key_ready", 64'(key_ready), 64'(!m_play));
    check_eq("busy", 64'(busy), 64'(m_play));
    check_eq("key_err", 64'(key_err), 64'(m_err));
    check_eq("play_valid", 64'(play_valid), 64'(m_play));
    check_eq("group_idx", 64'(group_idx), m_play ? 64'(m_pc) : 64'd0);
    for (int i = 0; i < 4; i++) check_eq("digit_onehot", 64'($onehot(digits[i])), 64'd1);
    if (m_play) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("digits_play", 64'(dig), 64'(e));
      end
    end else begin
      check_eq("digits_idle", 64'(dig), 64'(IDLE_PACK));
    end
  endtask

  task automatic step(input bit v, input logic [3:0] c, input bit clr);
    key_valid = v;
    key_code  = c;
    key_clear = clr;
    @(posedge clk);
    model_edge(v, c, clr);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic press(input logic [3:0] c);
    step(1'b1, c, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic press_list(input int keys [$]);
    foreach (keys[i]) press(4'(keys[i]));
  endtask

  initial begin
    #3;
    check_eq("rst_key_ready", 64'(key_ready), 64'd1);
    check_eq("rst_play_valid", 64'(play_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_key_err", 64'(key_err), 64'd0);
    check_eq("rst_group_idx", 64'(group_idx), 64'd0);
    check_eq("rst_digits", 64'(pack_digits()), 64'(IDLE_PACK));
    @(negedge clk);
    rst = 1'b0;

    // Basic entry; first group must be {C2,C7,C3,C0}
    press_list('{2, 7, 3, 0, 0, 0, 0, 0, 2, 7, 3, 0});
    check_eq("t1_group0_const", 64'(pack_digits()), 64'({C2, C7, C3, C0}));
    idle(4);

    // Illegal key in the middle
    press_list('{2, 7, 11, 3, 1, 4, 5, 6, 8, 9, 0, 1, 2});
    idle(4);

    // Partial entry then clear
    press_list('{1, 2, 3, 4, 5});
    step(1'b0, 4'd0, 1'b1);
    press_list('{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8});
    idle(4);

    // Continuous strobes: two back-to-back entries with play gap
    for (int i = 0; i < 15; i++) press(4'd5);
    for (int i = 0; i < 12; i++) press(4'($urandom_range(0, 9)));
    idle(4);

    // Reset in the middle of replay
    press_list('{3, 1, 4, 1, 5, 9, 2, 6, 5, 3, 5, 8});
    idle(1);
    check_eq("t5_pre_rst_group_idx", 64'(group_idx), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_rst_play_valid", 64'(play_valid), 64'd0);
    check_eq("t5_rst_digits", 64'(pack_digits()), 64'(IDLE_PACK));
    check_eq("t5_rst_key_ready", 64'(key_ready), 64'd1);
    m_play = 1'b0;
    m_pc   = 0;
    m_cnt  = 0;
    m_err  = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    press_list('{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3});
    idle(4);

    // Clear together with a key at key_cnt=7
    press_list('{6, 6, 6, 6, 7, 7, 7});
    step(1'b1, 4'd4, 1'b1);
    press_list('{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1});
    idle(4);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) != 0, 4'($urandom_range(0, 12)), ($urandom % 25) == 0);
    end
    idle(4);

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
